// File: rtl/encode_3to8.sv
// encode_3to8: registered 3-to-8 one-hot decoder with clock enable,
// a sticky valid flag and a one-cycle code-change strobe.
//
// Parameter OUT_ACTIVE_LOW inverts every bit of out (selected line low).
// out_valid and sel_chg are never inverted.
//
// Build option ENCODE_3TO8_COMB_OUT_EN: when defined, out is a purely
// combinational decode of the live select inputs (zero latency, ignores
// clk/rst/en). out_valid and sel_chg stay registered either way.
// Default (undefined): out is registered with one cycle of latency.
//
// Input qualification: en is a plain per-cycle qualifier, not a handshake.
// A rising clk edge with en=1 samples {sel1,sel2,sel3}; with en=0 every
// registered output holds, except sel_chg which returns to 0.
module encode_3to8 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sel1,
  input  logic       sel2,
  input  logic       sel3,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       sel_chg
);

  // Polarity mask applied to the decoded lines on the way out.
  localparam logic [7:0] INV_MASK = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [2:0] code;
  logic [7:0] dec;
  logic [2:0] last_code;

  assign code = {sel1, sel2, sel3};

  // One-hot decode of the live code; fully assigned so no latch is inferred.
  always_comb begin
    dec       = 8'h00;
    dec[code] = 1'b1;
  end

  // Valid flag, previous-code register and change strobe.
  // The strobe needs out_valid already set, so the first sample after
  // reset never reports a change regardless of last_code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sel_chg   <= 1'b0;
      last_code <= 3'b000;
    end else if (en) begin
      out_valid <= 1'b1;
      sel_chg   <= out_valid && (code != last_code);
      last_code <= code;
    end else begin
      sel_chg   <= 1'b0;
    end
  end

`ifdef ENCODE_3TO8_COMB_OUT_EN
  // Zero-latency output straight from the live select lines.
  assign out = dec ^ INV_MASK;
`else
  logic [7:0] dec_q;

  // Registered decode; held while en=0, all-zero (un-inverted) in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q <= 8'h00;
    end else if (en) begin
      dec_q <= dec;
    end
  end

  assign out = dec_q ^ INV_MASK;
`endif

endmodule

// File: tb/tb_encode_3to8.sv
// Directed testbench for encode_3to8 (default build, registered out).
// Two instances share the stimulus: active-high and active-low output.
module tb_encode_3to8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic clk_run;
  logic rst;
  logic en;
  logic sel1, sel2, sel3;

  logic [7:0] out_h;
  logic       valid_h;
  logic       chg_h;
  logic [7:0] out_l;
  logic       valid_l;
  logic       chg_l;

  int n_checks;
  int n_pass;

  initial begin
    clk     = 1'b0;
    clk_run = 1'b0;
  end

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  encode_3to8 #(.OUT_ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst(rst), .en(en),
    .sel1(sel1), .sel2(sel2), .sel3(sel3),
    .out(out_h), .out_valid(valid_h), .sel_chg(chg_h)
  );

  encode_3to8 #(.OUT_ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst(rst), .en(en),
    .sel1(sel1), .sel2(sel2), .sel3(sel3),
    .out(out_l), .out_valid(valid_l), .sel_chg(chg_l)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_code(input logic [2:0] c);
    {sel1, sel2, sel3} = c;
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check both instances against one expected one-hot value.
  task automatic expect_all(input string tag, input logic [7:0] onehot,
                            input logic valid, input logic chg);
    check({tag, " out"},       out_h,   onehot);
    check({tag, " out_n"},     out_l,   ~onehot);
    check({tag, " valid"},     {7'b0, valid_h}, {7'b0, valid});
    check({tag, " chg"},       {7'b0, chg_h},   {7'b0, chg});
    check({tag, " valid_n"},   {7'b0, valid_l}, {7'b0, valid});
    check({tag, " chg_n"},     {7'b0, chg_l},   {7'b0, chg});
  endtask

  // ---------------- stimulus ----------------
  // Hand-computed one-hot table for codes 000..111.
  logic [7:0] onehot_tbl [8];

  initial begin
    onehot_tbl[0] = 8'b0000_0001;
    onehot_tbl[1] = 8'b0000_0010;
    onehot_tbl[2] = 8'b0000_0100;
    onehot_tbl[3] = 8'b0000_1000;
    onehot_tbl[4] = 8'b0001_0000;
    onehot_tbl[5] = 8'b0010_0000;
    onehot_tbl[6] = 8'b0100_0000;
    onehot_tbl[7] = 8'b1000_0000;

    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    en       = 1'b0;
    set_code(3'b000);

    // 1. Reset pulse with clock stopped: outputs clear immediately.
    #3;
    rst = 1'b1;
    #2;
    expect_all("reset_noclk", 8'h00, 1'b0, 1'b0);
    check("reset_noclk out_n raw", out_l, 8'hFF);
    #2;
    rst = 1'b0;
    #2;

    clk_run = 1'b1;
    tick();
    // en=0 since reset: still nothing sampled.
    expect_all("idle_after_reset", 8'h00, 1'b0, 1'b0);

    // 2. Sweep all codes with en=1; first sample never strobes sel_chg.
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_code(3'(i));
      tick();
      expect_all($sformatf("sweep_%0d", i), onehot_tbl[i], 1'b1, (i != 0));
    end
    check("active_low code 011", 8'b1111_0111, ~onehot_tbl[3]);

    // 3. 111 -> 000 held for two cycles: one-cycle strobe.
    set_code(3'b000);
    tick();
    expect_all("back_to_000 a", onehot_tbl[0], 1'b1, 1'b1);
    tick();
    expect_all("back_to_000 b", onehot_tbl[0], 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_all($sformatf("hold_000_%0d", i), onehot_tbl[0], 1'b1, 1'b0);
    end

    // 4. Enable gating: change code under en=0, then release.
    set_code(3'b010);
    tick();
    expect_all("code_010", onehot_tbl[2], 1'b1, 1'b1);
    en = 1'b0;
    set_code(3'b101);
    tick();
    expect_all("en0 a", onehot_tbl[2], 1'b1, 1'b0);
    tick();
    expect_all("en0 b", onehot_tbl[2], 1'b1, 1'b0);
    en = 1'b1;
    tick();
    expect_all("en1_101", onehot_tbl[5], 1'b1, 1'b1);

    // Strobe must drop when en falls right after a change.
    set_code(3'b110);
    tick();
    expect_all("code_110", onehot_tbl[6], 1'b1, 1'b1);
    en = 1'b0;
    tick();
    expect_all("en0_after_chg", onehot_tbl[6], 1'b1, 1'b0);
    en = 1'b1;

    // Mid-operation async reset, held across an edge.
    #2;
    rst = 1'b1;
    #1;
    expect_all("reset_mid", 8'h00, 1'b0, 1'b0);
    tick();
    expect_all("reset_held", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // First enabled edge after reset acts as first sample.
    set_code(3'b101);
    tick();
    expect_all("post_reset_first", onehot_tbl[5], 1'b1, 1'b0);
    tick();
    expect_all("post_reset_same", onehot_tbl[5], 1'b1, 1'b0);
    set_code(3'b011);
    tick();
    expect_all("post_reset_chg", onehot_tbl[3], 1'b1, 1'b1);
    check("active_low live 011", out_l, 8'b1111_0111);

    // First sample after reset with a non-zero code, then return to 000:
    // last_code must have tracked the first sample, so 000 is a change.
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    set_code(3'b111);
    tick();
    expect_all("first_111", onehot_tbl[7], 1'b1, 1'b0);
    set_code(3'b000);
    tick();
    expect_all("then_000", onehot_tbl[0], 1'b1, 1'b1);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
